// File: rtl/lift_call_collector.sv
// Per-floor call collector: synchronises, debounces and edge-detects call buttons, latches
// pending calls and offers each one exactly once to the lift controller, round-robin by floor.
module lift_call_collector #(
    parameter int NUM_FLOORS      = 64,
    parameter int FLOOR_W         = 7,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic                  served_valid,
    input  logic [FLOOR_W-1:0]    served_floor,
    input  logic                  req_ready,
    output logic                  req_valid,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [NUM_FLOORS-1:0]   sync_meta;
    logic [NUM_FLOORS-1:0]   sync_btn;
    logic [NUM_FLOORS-1:0]   hist0;
    logic [NUM_FLOORS-1:0]   hist1;
    logic [NUM_FLOORS-1:0]   sent;
    logic [NUM_FLOORS-1:0]   press;
    logic [NUM_FLOORS-1:0]   served_hit;
    logic [NUM_FLOORS-1:0]   req_onehot;
    logic [NUM_FLOORS-1:0]   cand;
    logic [NUM_FLOORS-1:0]   cand_after;
    logic [CNT_W-1:0]        tick_cnt;
    logic                    tick;
    logic [FLOOR_W-1:0]      rr_ptr;
    logic [FLOOR_W-1:0]      rr_next_ptr;
    logic [FLOOR_W-1:0]      floor_next;
    logic                    accept;
    logic                    pick_any;
    logic                    pick2_any;
    logic [FLOOR_W-1:0]      pick_idx;
    logic [FLOOR_W-1:0]      pick2_idx;

    // Lowest candidate at or above ptr, otherwise the lowest candidate overall.
    function automatic logic [FLOOR_W:0] pick(input logic [NUM_FLOORS-1:0] c,
                                              input logic [FLOOR_W-1:0]    ptr);
        logic               found_hi;
        logic               found_lo;
        logic [FLOOR_W-1:0] hi;
        logic [FLOOR_W-1:0] lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi       = '0;
        lo       = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (c[i]) begin
                found_lo = 1'b1;
                lo       = FLOOR_W'(i);
                if (i >= int'(ptr)) begin
                    found_hi = 1'b1;
                    hi       = FLOOR_W'(i);
                end
            end
        end
        return found_hi ? {1'b1, hi} : {found_lo, lo};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_btn  <= '0;
        end else begin
            sync_meta <= btn;
            sync_btn  <= sync_meta;
        end
    end

    assign tick = (int'(tick_cnt) == DEBOUNCE_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            hist0    <= '0;
            hist1    <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                hist0 <= sync_btn;
                hist1 <= hist0;
            end
        end
    end

    // A press is one low sample followed by two high samples on consecutive ticks.
    assign press       = {NUM_FLOORS{tick}} & sync_btn & hist0 & ~hist1;
    assign served_hit  = (served_valid && int'(served_floor) < NUM_FLOORS)
                         ? (NUM_FLOORS'(1) << served_floor) : '0;
    assign req_onehot  = NUM_FLOORS'(1) << req_floor;
    assign cand        = pending & ~sent & ~served_hit;
    assign cand_after  = cand & ~req_onehot;
    assign rr_next_ptr = (int'(req_floor) == NUM_FLOORS - 1) ? '0 : req_floor + 1'b1;
    assign {pick_any, pick_idx}   = pick(cand, rr_ptr);
    assign {pick2_any, pick2_idx} = pick(cand_after, rr_next_ptr);

    always_comb begin
        state_next = state;
        floor_next = req_floor;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = OFFER;
                    floor_next = pick_idx;
                end
            end
            OFFER: begin
                if (req_ready) begin
                    accept = 1'b1;
                    if (pick2_any) begin
                        floor_next = pick2_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (served_valid && served_floor == req_floor) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_floor <= '0;
            rr_ptr    <= '0;
            pending   <= '0;
            sent      <= '0;
        end else begin
            state     <= state_next;
            req_floor <= floor_next;
            if (accept) begin
                rr_ptr <= rr_next_ptr;
            end
            // Retire wins over a same-cycle press or handshake on that floor.
            pending <= (pending | press) & ~served_hit;
            sent    <= (sent | (accept ? req_onehot : '0)) & ~served_hit;
        end
    end

    assign req_valid = (state == OFFER);
    assign busy      = |pending;

endmodule

// File: tb/tb_lift_call_collector.sv
// Randomised and directed bench for lift_call_collector: a reference model predicts per-cycle
// outputs and the order of accepted requests; a monitor compares them against the DUT.
module tb_lift_call_collector;

    localparam int N  = 64;
    localparam int FW = 7;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  btn;
    logic          served_valid;
    logic [FW-1:0] served_floor;
    logic          req_ready;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic [N-1:0]  pending;
    logic          busy;

    lift_call_collector #(
        .NUM_FLOORS(N),
        .FLOOR_W(FW),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .served_valid(served_valid),
        .served_floor(served_floor),
        .req_ready(req_ready),
        .req_valid(req_valid),
        .req_floor(req_floor),
        .pending(pending),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         valid;
        int         floor;
        bit         chk_floor;
        bit [N-1:0] pend;
    } snap_t;

    snap_t snap_q[$];
    int    hs_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    bit    done     = 1'b0;

    // Reference model state: what the outputs should show during the current cycle.
    bit [N-1:0] m_pend, m_sent, m_dly1, m_dly2, m_s0, m_s1;
    bit [N-1:0] m_press, m_hit, m_cand;
    int         m_cnt, m_rr, m_floor, m_f;
    bit         m_offer, m_after_reset, m_tick;
    snap_t      m_snap;

    function automatic int choose(bit [N-1:0] c, int ptr);
        for (int k = 0; k < N; k++) begin
            if (c[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] b, input logic sv,
                                 input logic [FW-1:0] sf, input logic rdy, input int n);
        reset        = r;
        btn          = b;
        served_valid = sv;
        served_floor = sf;
        req_ready    = rdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        m_pend = '0; m_sent = '0; m_dly1 = '0; m_dly2 = '0; m_s0 = '0; m_s1 = '0;
        m_cnt = 0; m_rr = 0; m_floor = 0; m_offer = 1'b0; m_after_reset = 1'b1;
        forever begin
            @(negedge clk);
            if (done) break;
            m_snap.valid     = m_offer;
            m_snap.floor     = m_floor;
            m_snap.chk_floor = m_offer || m_after_reset;
            m_snap.pend      = m_pend;
            snap_q.push_back(m_snap);
            if (reset) begin
                m_pend = '0; m_sent = '0; m_dly1 = '0; m_dly2 = '0; m_s0 = '0; m_s1 = '0;
                m_cnt = 0; m_rr = 0; m_floor = 0; m_offer = 1'b0; m_after_reset = 1'b1;
            end else begin
                m_hit = '0;
                if (served_valid && served_floor < N) m_hit[served_floor] = 1'b1;
                m_tick  = (m_cnt == D - 1);
                m_cnt   = m_tick ? 0 : m_cnt + 1;
                m_press = m_tick ? (m_dly2 & m_s0 & ~m_s1) : '0;
                if (m_tick) begin
                    m_s1 = m_s0;
                    m_s0 = m_dly2;
                end
                m_dly2 = m_dly1;
                m_dly1 = btn;
                m_cand = m_pend & ~m_sent & ~m_hit;
                if (!m_offer) begin
                    m_f = choose(m_cand, m_rr);
                    if (m_f >= 0) begin
                        m_offer       = 1'b1;
                        m_floor       = m_f;
                        m_after_reset = 1'b0;
                    end
                end else if (req_ready) begin
                    hs_q.push_back(m_floor);
                    m_sent[m_floor] = 1'b1;
                    m_rr            = (m_floor + 1) % N;
                    m_cand[m_floor] = 1'b0;
                    m_f             = choose(m_cand, m_rr);
                    if (m_f >= 0) m_floor = m_f;
                    else          m_offer = 1'b0;
                end else if (served_valid && served_floor == m_floor) begin
                    m_offer = 1'b0;
                end
                m_pend = (m_pend | m_press) & ~m_hit;
                m_sent = m_sent & ~m_hit;
            end
        end
    end

    initial begin
        snap_t s;
        int    e;
        forever begin
            @(negedge clk);
            #1;
            if (done) break;
            if (snap_q.size() == 0) begin
                checkOutput("snapshot_available", 64'd0, 64'd1);
            end else begin
                s = snap_q.pop_front();
                checkOutput("req_valid", 64'(req_valid), 64'(s.valid));
                if (s.chk_floor) checkOutput("req_floor", 64'(req_floor), 64'(s.floor));
                checkOutput("pending", 64'(pending), 64'(s.pend));
                checkOutput("busy", 64'(busy), 64'(|s.pend));
            end
            if (req_valid === 1'b1 && req_ready && !reset) begin
                if (hs_q.size() == 0) begin
                    checkOutput("handshake_expected", 64'(req_floor), 64'hFFFF);
                end else begin
                    e = hs_q.pop_front();
                    checkOutput("handshake_floor", 64'(req_floor), 64'(e));
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rb;
        logic         rsv;
        logic [FW-1:0] rsf;
        applyStimulus(1, '1, 0, 0, 0, 3);
        applyStimulus(0, '0, 0, 0, 0, 3 * D);
        // single call on floor 5
        applyStimulus(0, N'(1) << 5, 0, 0, 1, 3 * D);
        applyStimulus(0, '0, 0, 0, 1, 6);
        applyStimulus(0, '0, 1, 5, 1, 1);
        applyStimulus(0, '0, 0, 0, 1, 3);
        // glitch shorter than a tick period, then a long hold
        applyStimulus(0, N'(1) << 9, 0, 0, 1, D - 1);
        applyStimulus(0, '0, 0, 0, 1, 4 * D);
        applyStimulus(0, N'(1) << 9, 0, 0, 1, 100);
        applyStimulus(0, '0, 1, 9, 1, 1);
        applyStimulus(0, '0, 0, 0, 1, 3);
        // move pointer to 41, then 2/40/63 under backpressure
        applyStimulus(0, N'(1) << 40, 0, 0, 1, 3 * D);
        applyStimulus(0, '0, 0, 0, 1, 4);
        applyStimulus(0, '0, 1, 40, 0, 1);
        applyStimulus(0, (N'(1) << 2) | (N'(1) << 40) | (N'(1) << 63), 0, 0, 0, 3 * D);
        applyStimulus(0, '0, 0, 0, 0, 5);
        applyStimulus(0, '0, 0, 0, 1, 5);
        applyStimulus(0, '0, 1, 63, 0, 1);
        applyStimulus(0, '0, 1, 2, 0, 1);
        applyStimulus(0, '0, 1, 40, 0, 1);
        // withdraw, then press and retire coinciding
        applyStimulus(0, N'(1) << 12, 0, 0, 0, 3 * D);
        applyStimulus(0, '0, 0, 0, 0, 3);
        applyStimulus(0, '0, 1, 12, 0, 1);
        applyStimulus(0, '0, 0, 0, 0, 3);
        applyStimulus(0, N'(1) << 12, 1, 12, 0, 3 * D + 4);
        applyStimulus(0, '0, 0, 0, 0, 3 * D);
        // out-of-range retire, reset mid-offer, re-press after reset
        applyStimulus(0, N'(1) | (N'(1) << 7), 0, 0, 0, 3 * D);
        applyStimulus(0, '0, 1, 64, 0, 1);
        applyStimulus(0, '0, 1, 127, 0, 1);
        applyStimulus(0, '0, 0, 0, 0, 3);
        applyStimulus(1, '0, 0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 0, 3);
        applyStimulus(0, N'(1), 0, 0, 1, 3 * D);
        applyStimulus(0, '0, 0, 0, 1, 3);
        applyStimulus(0, '0, 1, 0, 1, 1);
        rb = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) rb[$urandom_range(0, N - 1)] ^= 1'b1;
            rsv = ($urandom_range(0, 3) == 0);
            rsf = FW'($urandom_range(0, N + 5));
            applyStimulus(($urandom_range(0, 399) == 0), rb, rsv, rsf,
                          ($urandom_range(0, 2) != 0), 1);
        end
        applyStimulus(0, '0, 0, 0, 0, 4 * D);
        done = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("handshake_drain", 64'(hs_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
